// File: rtl/stopwatch_ctrl_if.sv
// Purpose: control and display bundle for stopwatch_ctrl.
// Ports (signals):
//   tick_1hz, tick_2hz   : one-cycle rate enables (count / adjust)
//   pause_pulse          : one-cycle pause/resume request
//   clr_pulse            : one-cycle clear request
//   adj, sel             : adjust-mode level and field select (0=min, 1=sec)
//   min1, min0, sec1, sec0 : BCD time digits
//   running, blink_en, blink_sel : status for the display
interface stopwatch_ctrl_if;
  logic       tick_1hz;
  logic       tick_2hz;
  logic       pause_pulse;
  logic       clr_pulse;
  logic       adj;
  logic       sel;
  logic [2:0] min1;
  logic [3:0] min0;
  logic [2:0] sec1;
  logic [3:0] sec0;
  logic       running;
  logic       blink_en;
  logic       blink_sel;

  // Stimulus / controller side
  modport master (
    output tick_1hz, tick_2hz, pause_pulse, clr_pulse, adj, sel,
    input  min1, min0, sec1, sec0, running, blink_en, blink_sel
  );

  // Stopwatch side
  modport slave (
    input  tick_1hz, tick_2hz, pause_pulse, clr_pulse, adj, sel,
    output min1, min0, sec1, sec0, running, blink_en, blink_sel
  );
endinterface

// File: rtl/stopwatch_ctrl.sv
// Purpose: BCD mm:ss stopwatch with run/pause/adjust control.
// Ports:
//   clk   : system clock, all state changes on the rising edge
//   rst_n : synchronous active-low reset
//   sw    : stopwatch_ctrl_if.slave (ticks, requests, digits, status)
module stopwatch_ctrl #(
  parameter int unsigned MAX_MIN = 59
) (
  input  logic             clk,
  input  logic             rst_n,
  stopwatch_ctrl_if.slave  sw
);

  localparam int unsigned W_TENS = 3;
  localparam int unsigned W_ONES = 4;
  localparam int unsigned MAX_M1 = MAX_MIN / 10;
  localparam int unsigned MAX_M0 = MAX_MIN % 10;

  typedef enum logic [1:0] {
    ST_RUN   = 2'd0,
    ST_PAUSE = 2'd1,
    ST_ADJ   = 2'd2
  } state_t;

  state_t              r_state;
  state_t              w_state_nxt;
  logic                r_was_paused;
  logic                w_was_paused_nxt;

  logic [W_TENS-1:0]   r_min1, r_sec1;
  logic [W_ONES-1:0]   r_min0, r_sec0;
  logic [W_TENS-1:0]   w_min1_nxt, w_sec1_nxt;
  logic [W_ONES-1:0]   w_min0_nxt, w_sec0_nxt;

  logic [W_TENS-1:0]   w_min1_inc, w_sec1_inc;
  logic [W_ONES-1:0]   w_min0_inc, w_sec0_inc;
  logic                w_sec_wrap;
  logic                w_min_wrap;

  logic                r_running;
  logic                r_blink_en;
  logic                r_blink_sel;

  // Wrap-aware +1 of each field, shared by counting and adjusting
  always_comb begin
    w_sec_wrap = (r_sec1 == W_TENS'(5)) && (r_sec0 == W_ONES'(9));
    w_min_wrap = (r_min1 == W_TENS'(MAX_M1)) && (r_min0 == W_ONES'(MAX_M0));

    w_sec1_inc = r_sec1;
    w_sec0_inc = r_sec0 + W_ONES'(1);
    if (r_sec0 == W_ONES'(9)) begin
      w_sec0_inc = '0;
      w_sec1_inc = w_sec_wrap ? '0 : r_sec1 + W_TENS'(1);
    end

    w_min1_inc = r_min1;
    w_min0_inc = r_min0 + W_ONES'(1);
    if (w_min_wrap) begin
      w_min1_inc = '0;
      w_min0_inc = '0;
    end else if (r_min0 == W_ONES'(9)) begin
      w_min0_inc = '0;
      w_min1_inc = r_min1 + W_TENS'(1);
    end
  end

  // Next state and next time, in priority clear > adj transition > pause > tick
  always_comb begin
    w_state_nxt      = r_state;
    w_was_paused_nxt = r_was_paused;
    w_min1_nxt       = r_min1;
    w_min0_nxt       = r_min0;
    w_sec1_nxt       = r_sec1;
    w_sec0_nxt       = r_sec0;

    if (sw.clr_pulse) begin
      w_min1_nxt = '0;
      w_min0_nxt = '0;
      w_sec1_nxt = '0;
      w_sec0_nxt = '0;
    end else if ((r_state != ST_ADJ) && sw.adj) begin
      w_state_nxt      = ST_ADJ;
      w_was_paused_nxt = (r_state == ST_PAUSE);
    end else if ((r_state == ST_ADJ) && !sw.adj) begin
      w_state_nxt = r_was_paused ? ST_PAUSE : ST_RUN;
    end else begin
      case (r_state)
        ST_RUN: begin
          if (sw.tick_1hz) begin
            w_sec1_nxt = w_sec1_inc;
            w_sec0_nxt = w_sec0_inc;
            if (w_sec_wrap) begin
              w_min1_nxt = w_min1_inc;
              w_min0_nxt = w_min0_inc;
            end
          end
          // Increment and pause may share an edge
          if (sw.pause_pulse) begin
            w_state_nxt = ST_PAUSE;
          end
        end
        ST_PAUSE: begin
          if (sw.pause_pulse) begin
            w_state_nxt = ST_RUN;
          end
        end
        ST_ADJ: begin
          // Field adjust wraps on its own, no carry across fields
          if (sw.tick_2hz) begin
            if (sw.sel) begin
              w_sec1_nxt = w_sec1_inc;
              w_sec0_nxt = w_sec0_inc;
            end else begin
              w_min1_nxt = w_min1_inc;
              w_min0_nxt = w_min0_inc;
            end
          end
        end
        default: begin
          w_state_nxt = ST_RUN;
        end
      endcase
    end
  end

  // State register
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state      <= ST_RUN;
      r_was_paused <= 1'b0;
    end else begin
      r_state      <= w_state_nxt;
      r_was_paused <= w_was_paused_nxt;
    end
  end

  // Time digits and status outputs, registered from next-state values
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_min1      <= '0;
      r_min0      <= '0;
      r_sec1      <= '0;
      r_sec0      <= '0;
      r_running   <= 1'b1;
      r_blink_en  <= 1'b0;
      r_blink_sel <= 1'b0;
    end else begin
      r_min1      <= w_min1_nxt;
      r_min0      <= w_min0_nxt;
      r_sec1      <= w_sec1_nxt;
      r_sec0      <= w_sec0_nxt;
      r_running   <= (w_state_nxt == ST_RUN);
      r_blink_en  <= (w_state_nxt == ST_ADJ);
      r_blink_sel <= sw.sel;
    end
  end

  assign sw.min1      = r_min1;
  assign sw.min0      = r_min0;
  assign sw.sec1      = r_sec1;
  assign sw.sec0      = r_sec0;
  assign sw.running   = r_running;
  assign sw.blink_en  = r_blink_en;
  assign sw.blink_sel = r_blink_sel;

endmodule

// File: tb/tb_stopwatch_ctrl.sv
// Purpose: self-checking bench for stopwatch_ctrl; a seconds-based reference
// model predicts the display every cycle under directed and random stimulus.
module tb_stopwatch_ctrl;

  localparam int unsigned MAX_MIN = 59;
  localparam int unsigned PERIOD  = (MAX_MIN + 1) * 60;
  localparam int M_RUN   = 0;
  localparam int M_PAUSE = 1;
  localparam int M_ADJ   = 2;

  logic clk;
  logic rst_n;
  stopwatch_ctrl_if sw_if ();

  stopwatch_ctrl #(.MAX_MIN(MAX_MIN)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .sw    (sw_if.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks;
  int failures;

  // Reference model: total elapsed seconds plus mode
  int m_t;
  int m_mode;
  bit m_wp;
  bit m_bsel;

  task automatic chk(input string tag, input int got, input int exp);
    checks++;
    if (got != exp) begin
      failures++;
      $display("FAIL %s got=0x%0h exp=0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic int bcd_of(input int t);
    int m, s;
    m = t / 60;
    s = t % 60;
    return ((m / 10) << 12) | ((m % 10) << 8) | ((s / 10) << 4) | (s % 10);
  endfunction

  function automatic int dut_time();
    return int'({1'b0, sw_if.min1, sw_if.min0, 1'b0, sw_if.sec1, sw_if.sec0});
  endfunction

  function automatic int dut_flags();
    return int'({sw_if.running, sw_if.blink_en, sw_if.blink_sel});
  endfunction

  task automatic model_step();
    int m, s;
    m = m_t / 60;
    s = m_t % 60;
    if (!rst_n) begin
      m_t = 0; m_mode = M_RUN; m_wp = 1'b0; m_bsel = 1'b0;
    end else begin
      m_bsel = sw_if.sel;
      if (sw_if.clr_pulse) begin
        m_t = 0;
      end else if (m_mode != M_ADJ && sw_if.adj) begin
        m_wp   = (m_mode == M_PAUSE);
        m_mode = M_ADJ;
      end else if (m_mode == M_ADJ && !sw_if.adj) begin
        m_mode = m_wp ? M_PAUSE : M_RUN;
      end else if (m_mode == M_RUN) begin
        if (sw_if.tick_1hz) m_t = (m_t + 1) % PERIOD;
        if (sw_if.pause_pulse) m_mode = M_PAUSE;
      end else if (m_mode == M_PAUSE) begin
        if (sw_if.pause_pulse) m_mode = M_RUN;
      end else if (sw_if.tick_2hz) begin
        if (sw_if.sel) m_t = m * 60 + (s + 1) % 60;
        else           m_t = ((m + 1) % (MAX_MIN + 1)) * 60 + s;
      end
    end
  endtask

  // One clock: edge, advance model, check, then drop pulses
  task automatic cyc();
    @(posedge clk);
    model_step();
    #1;
    chk("time", dut_time(), bcd_of(m_t));
    chk("flags", dut_flags(),
        int'({m_mode == M_RUN, m_mode == M_ADJ, m_bsel}));
    sw_if.tick_1hz    = 1'b0;
    sw_if.tick_2hz    = 1'b0;
    sw_if.pause_pulse = 1'b0;
    sw_if.clr_pulse   = 1'b0;
  endtask

  // Load mm:ss through adjust mode and return to the prior run/pause state
  task automatic goto(input int mm, input int ss);
    sw_if.clr_pulse = 1'b1; cyc();
    sw_if.adj = 1'b1; sw_if.sel = 1'b0; cyc();
    for (int i = 0; i < mm; i++) begin sw_if.tick_2hz = 1'b1; cyc(); end
    sw_if.sel = 1'b1;
    for (int i = 0; i < ss; i++) begin sw_if.tick_2hz = 1'b1; cyc(); end
    sw_if.adj = 1'b0; cyc();
  endtask

  initial begin
    checks = 0; failures = 0;
    m_t = 0; m_mode = M_RUN; m_wp = 1'b0; m_bsel = 1'b0;
    rst_n = 1'b0;
    sw_if.tick_1hz = 1'b0; sw_if.tick_2hz = 1'b0;
    sw_if.pause_pulse = 1'b0; sw_if.clr_pulse = 1'b0;
    sw_if.adj = 1'b0; sw_if.sel = 1'b0;

    cyc(); cyc();
    chk("reset_time", dut_time(), 'h0000);
    chk("reset_flags", dut_flags(), 3'b100);
    rst_n = 1'b1;
    cyc();

    // 61 seconds
    for (int i = 0; i < 61; i++) begin sw_if.tick_1hz = 1'b1; cyc(); end
    chk("t61", dut_time(), 'h0101);
    chk("t61_run", int'(sw_if.running), 1);

    // Full wrap and minute carry
    goto(59, 59);
    sw_if.tick_1hz = 1'b1; cyc();
    chk("wrap_5959", dut_time(), 'h0000);
    goto(9, 59);
    sw_if.tick_1hz = 1'b1; cyc();
    chk("carry_0959", dut_time(), 'h1000);

    // Pause holds time
    sw_if.pause_pulse = 1'b1; cyc();
    for (int i = 0; i < 5; i++) begin sw_if.tick_1hz = 1'b1; cyc(); end
    chk("paused_time", dut_time(), 'h1000);
    chk("paused_run", int'(sw_if.running), 0);
    sw_if.pause_pulse = 1'b1; cyc();
    sw_if.tick_1hz = 1'b1; cyc();
    chk("resumed", dut_time(), 'h1001);

    // Adjust seconds from pause, no carry into minutes
    goto(12, 34);
    sw_if.pause_pulse = 1'b1; cyc();
    sw_if.adj = 1'b1; sw_if.sel = 1'b1; cyc();
    for (int i = 0; i < 30; i++) begin sw_if.tick_2hz = 1'b1; cyc(); end
    chk("adj_sec", dut_time(), 'h1204);
    chk("adj_flags", dut_flags(), 3'b011);
    sw_if.adj = 1'b0; cyc();
    chk("adj_exit", dut_flags(), 3'b001);
    sw_if.pause_pulse = 1'b1; cyc();

    // Tick with pause, clear with tick
    goto(0, 9);
    sw_if.tick_1hz = 1'b1; sw_if.pause_pulse = 1'b1; cyc();
    chk("tick_pause", dut_time(), 'h0010);
    chk("tick_pause_run", int'(sw_if.running), 0);
    sw_if.pause_pulse = 1'b1; cyc();
    sw_if.clr_pulse = 1'b1; sw_if.tick_1hz = 1'b1; cyc();
    chk("clr_tick", dut_time(), 'h0000);

    // Reset while adjusting
    goto(33, 33);
    sw_if.adj = 1'b1; sw_if.sel = 1'b0; cyc();
    rst_n = 1'b0; sw_if.tick_2hz = 1'b1; cyc();
    chk("rst_adj_time", dut_time(), 'h0000);
    chk("rst_adj_flags", dut_flags(), 3'b100);
    rst_n = 1'b1; sw_if.adj = 1'b0; cyc();

    // Random traffic against the model
    for (int i = 0; i < 3000; i++) begin
      sw_if.tick_1hz    = ($urandom_range(0, 99) < 40);
      sw_if.tick_2hz    = ($urandom_range(0, 99) < 40);
      sw_if.pause_pulse = ($urandom_range(0, 99) < 6);
      sw_if.clr_pulse   = ($urandom_range(0, 99) < 2);
      if ($urandom_range(0, 99) < 3)  sw_if.adj = ~sw_if.adj;
      if ($urandom_range(0, 99) < 10) sw_if.sel = ~sw_if.sel;
      rst_n = ($urandom_range(0, 199) != 0);
      cyc();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
